// File: rtl/prim_secded_inv_codec_pipe.sv
// Two-stage pipelined inverted-Hsiao SECDED encoder/decoder with per-beat mode select,
// saturating error counters and a sticky first-error syndrome capture.
module prim_secded_inv_codec_pipe #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned CntWidth  = 8,
    localparam int unsigned CodeWidth = (DataWidth == 32) ? 39 : 22,
    localparam int unsigned ParWidth  = CodeWidth - DataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_mode_i,
    input  logic [CodeWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CodeWidth-1:0] out_data_o,
    output logic [1:0]           out_err_o,
    input  logic                 clr_i,
    output logic [CntWidth-1:0]  corr_cnt_o,
    output logic [CntWidth-1:0]  uncorr_cnt_o,
    output logic                 cap_valid_o,
    output logic [ParWidth-1:0]  cap_syndrome_o
);

    if (!(DataWidth == 16 || DataWidth == 32)) begin : gen_bad_data_width
        $error("DataWidth must be 16 or 32");
    end
    if (CntWidth < 1 || CntWidth > 32) begin : gen_bad_cnt_width
        $error("CntWidth must be in 1..32");
    end

    localparam logic [38:0] InvConstFull = (DataWidth == 32) ? 39'h2A_0000_0000 : 39'h00_002A_0000;
    localparam logic [CodeWidth-1:0] InvConst = InvConstFull[CodeWidth-1:0];

    // Data-bit coverage of check bit k.
    function automatic logic [CodeWidth-1:0] mask_of(input int unsigned k);
        logic [38:0] m;
        m = '0;
        if (DataWidth == 16) begin
            case (k)
                0: m = 39'h00_0000_496E;
                1: m = 39'h00_0000_F20B;
                2: m = 39'h00_0000_8ED8;
                3: m = 39'h00_0000_7714;
                4: m = 39'h00_0000_ACA5;
                5: m = 39'h00_0000_11F3;
                default: m = '0;
            endcase
        end else begin
            case (k)
                0: m = 39'h00_2606_BD25;
                1: m = 39'h00_DEBA_8050;
                2: m = 39'h00_413D_89AA;
                3: m = 39'h00_3123_4ED1;
                4: m = 39'h00_C2C1_323B;
                5: m = 39'h00_2DCC_624C;
                6: m = 39'h00_9850_5586;
                default: m = '0;
            endcase
        end
        return m[CodeWidth-1:0];
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_mode_q, s1_mode_d;
    logic [CodeWidth-1:0] s1_data_q, s1_data_d;
    logic [ParWidth-1:0]  s1_syn_q, s1_syn_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_mode_q, s2_mode_d;
    logic [CodeWidth-1:0] s2_data_q, s2_data_d;
    logic [1:0]           s2_err_q, s2_err_d;
    logic [ParWidth-1:0]  s2_syn_q, s2_syn_d;
    logic [CntWidth-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CntWidth-1:0]  uncorr_cnt_q, uncorr_cnt_d;
    logic                 cap_valid_q, cap_valid_d;
    logic [ParWidth-1:0]  cap_syn_q, cap_syn_d;

    logic                 s2_ready;
    logic                 out_fire;
    logic [CodeWidth-1:0] in_u, chk_mask;
    logic [ParWidth-1:0]  in_syn;
    logic [CodeWidth-1:0] enc, dec_u, mk, s2_data_calc;
    logic [ParWidth-1:0]  col;
    logic [1:0]           s2_err_calc;

    assign s2_ready   = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s2_ready;
    assign out_fire   = s2_valid_q && out_ready_i;

    always_comb begin
        in_u     = in_data_i ^ InvConst;
        in_syn   = '0;
        chk_mask = '0;
        for (int k = 0; k < ParWidth; k++) begin
            chk_mask = mask_of(k);
            chk_mask[DataWidth + k] = 1'b1;
            in_syn[k] = ^(in_u & chk_mask);
        end
    end

    always_comb begin
        s2_data_calc = '0;
        s2_err_calc  = '0;
        dec_u        = s1_data_q ^ InvConst;
        enc          = '0;
        mk           = '0;
        col          = '0;
        if (!s1_mode_q) begin
            enc[DataWidth-1:0] = s1_data_q[DataWidth-1:0];
            for (int k = 0; k < ParWidth; k++) begin
                mk = mask_of(k);
                enc[DataWidth + k] = ^(enc & mk);
            end
            s2_data_calc = enc ^ InvConst;
        end else begin
            s2_data_calc[DataWidth-1:0] = dec_u[DataWidth-1:0];
            if (s1_syn_q != '0) begin
                if (^s1_syn_q) begin
                    s2_err_calc = 2'b01;
                    // Flip the data bit whose H column matches; check-bit hits match none.
                    for (int i = 0; i < DataWidth; i++) begin
                        for (int k = 0; k < ParWidth; k++) begin
                            mk = mask_of(k);
                            col[k] = mk[i];
                        end
                        if (col == s1_syn_q) s2_data_calc[i] = ~s2_data_calc[i];
                    end
                end else begin
                    s2_err_calc = 2'b10;
                end
            end
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_mode_d    = s1_mode_q;
        s1_data_d    = s1_data_q;
        s1_syn_d     = s1_syn_q;
        s2_valid_d   = s2_valid_q;
        s2_mode_d    = s2_mode_q;
        s2_data_d    = s2_data_q;
        s2_err_d     = s2_err_q;
        s2_syn_d     = s2_syn_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        cap_valid_d  = cap_valid_q;
        cap_syn_d    = cap_syn_q;

        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_mode_d = in_mode_i;
                s1_data_d = in_data_i;
                s1_syn_d  = in_syn;
            end
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_d = s1_mode_q;
                s2_data_d = s2_data_calc;
                s2_err_d  = s2_err_calc;
                s2_syn_d  = s1_syn_q;
            end
        end

        // A clear beats a simultaneous error transfer.
        if (clr_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
            cap_valid_d  = 1'b0;
            cap_syn_d    = '0;
        end else if (out_fire && s2_mode_q) begin
            if (s2_err_q[0] && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CntWidth'(1);
            if (s2_err_q[1] && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CntWidth'(1);
            if (s2_err_q != 2'b00 && !cap_valid_q) begin
                cap_valid_d = 1'b1;
                cap_syn_d   = s2_syn_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_mode_q    <= 1'b0;
            s2_data_q    <= '0;
            s2_err_q     <= '0;
            s2_syn_q     <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            cap_valid_q  <= 1'b0;
            cap_syn_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            s2_valid_q   <= s2_valid_d;
            s2_mode_q    <= s2_mode_d;
            s2_data_q    <= s2_data_d;
            s2_err_q     <= s2_err_d;
            s2_syn_q     <= s2_syn_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            cap_valid_q  <= cap_valid_d;
            cap_syn_q    <= cap_syn_d;
        end
    end

    assign out_valid_o    = s2_valid_q;
    assign out_data_o     = s2_data_q;
    assign out_err_o      = s2_err_q;
    assign corr_cnt_o     = corr_cnt_q;
    assign uncorr_cnt_o   = uncorr_cnt_q;
    assign cap_valid_o    = cap_valid_q;
    assign cap_syndrome_o = cap_syn_q;

endmodule
